// File: rtl/wb_port_sched.sv
// wb_port_sched: arbitrates the RF write port between single-cycle writebacks and one outstanding load (timeout under WBS_TIMEOUT_EN)
module wb_port_sched #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic       wb_en,
  input  logic [1:0] wb_src,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       mem_rsp_valid,
  output logic [1:0] ru_data_wr_src,
  output logic       ru_wr,
  output logic [4:0] ru_rd,
  output logic       stall,
  output logic       load_pending,
  output logic       load_err
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t state, state_nxt;
  logic [4:0] pend_rd;
  logic busy, rd_nz, hazard, accept, start, rsp_wr, single_wr, tmo;
  if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end
`ifdef WBS_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;
  assign tmo = busy & ~mem_rsp_valid & (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // wait counter: cleared on load issue, saturating count while waiting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt <= '0;
    else if (start) wait_cnt <= '0;
    else if (busy && wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
  // sticky timeout flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) load_err <= 1'b0;
    else if (tmo) load_err <= 1'b1;
`else
  assign tmo = 1'b0;
  assign load_err = 1'b0;
`endif
  // hazard detection, port arbitration and next-state selection
  always_comb begin
    busy = state == WAIT_LOAD;
    rd_nz = rd != 5'd0;
    hazard = rs1 == pend_rd || rs2 == pend_rd || (wb_en && rd == pend_rd) ||
             (wb_src == 2'b01 && wb_en && rd_nz) || (mem_rsp_valid && wb_en && rd_nz);
    stall = busy & instr_valid & hazard;
    accept = instr_valid & ~stall;
    start = ~busy & accept & wb_en & rd_nz & (wb_src == 2'b01);
    rsp_wr = busy & mem_rsp_valid;
    single_wr = accept & wb_en & rd_nz & ~wb_src[0];
    ru_wr = rsp_wr | single_wr;
    ru_rd = rsp_wr ? pend_rd : single_wr ? rd : 5'd0;
    ru_data_wr_src = rsp_wr ? 2'b01 : single_wr ? wb_src : 2'b00;
    load_pending = busy;
    state_nxt = busy ? ((mem_rsp_valid || tmo) ? IDLE : WAIT_LOAD) : (start ? WAIT_LOAD : IDLE);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // destination of the outstanding load
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend_rd <= 5'd0;
    else if (start) pend_rd <= rd;
endmodule

// File: tb/tb_wb_port_sched.sv
// tb_wb_port_sched: directed checks of writeback port scheduling (timeout checks under WBS_TIMEOUT_EN)
module tb_wb_port_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  logic instr_valid = 0, wb_en = 0, mem_rsp_valid = 0;
  logic [1:0] wb_src = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [1:0] ru_data_wr_src;
  logic ru_wr, stall, load_pending, load_err;
  logic [4:0] ru_rd;
  logic [9:0] obs;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign obs = {ru_wr, ru_rd, ru_data_wr_src, stall, load_pending};
  wb_port_sched #(.TIMEOUT_CYCLES(4), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .wb_en(wb_en), .wb_src(wb_src),
    .rd(rd), .rs1(rs1), .rs2(rs2), .mem_rsp_valid(mem_rsp_valid),
    .ru_data_wr_src(ru_data_wr_src), .ru_wr(ru_wr), .ru_rd(ru_rd), .stall(stall),
    .load_pending(load_pending), .load_err(load_err));
  task automatic drive(input logic iv, input logic we, input logic [1:0] src, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic mv);
    {instr_valid, wb_en, wb_src, rd, rs1, rs2, mem_rsp_valid} = {iv, we, src, d, s1, s2, mv};
    #1;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 0;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
    total++; if (obs !== 10'b0) begin bad++; $display("FAIL reset_outs got=%b exp=%b", obs, 10'b0); end
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", load_err); end
    @(negedge clk); rst_n = 1; step;
  endtask
  task automatic test_alu;
    drive(1'b1, 1'b1, 2'b00, 5'd5, 5'd1, 5'd2, 1'b0);
    total++; if (obs !== {1'b1, 5'd5, 2'b00, 2'b00}) begin bad++; $display("FAIL alu_write got=%b exp=%b", obs, {1'b1, 5'd5, 2'b00, 2'b00}); end
    step;
    drive(1'b1, 1'b1, 2'b00, 5'd0, 5'd1, 5'd2, 1'b0);
    total++; if (obs !== 10'b0) begin bad++; $display("FAIL alu_x0 got=%b exp=%b", obs, 10'b0); end
    step;
  endtask
  task automatic test_load;
    drive(1'b1, 1'b1, 2'b01, 5'd7, 5'd0, 5'd0, 1'b0);
    total++; if (obs !== 10'b0) begin bad++; $display("FAIL load_issue got=%b exp=%b", obs, 10'b0); end
    step;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      total++; if (obs !== 10'b1) begin bad++; $display("FAIL load_wait%0d got=%b exp=%b", i, obs, 10'b1); end
      step;
    end
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b1);
    total++; if (obs !== {1'b1, 5'd7, 2'b01, 2'b01}) begin bad++; $display("FAIL load_rsp got=%b exp=%b", obs, {1'b1, 5'd7, 2'b01, 2'b01}); end
    step;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
    total++; if (obs !== 10'b0) begin bad++; $display("FAIL load_done got=%b exp=%b", obs, 10'b0); end
  endtask
  task automatic test_raw;
    drive(1'b1, 1'b1, 2'b01, 5'd7, 5'd0, 5'd0, 1'b0); step;
    drive(1'b1, 1'b1, 2'b00, 5'd3, 5'd7, 5'd0, 1'b0);
    total++; if (obs !== 10'b0000000011) begin bad++; $display("FAIL raw_stall got=%b exp=%b", obs, 10'b0000000011); end
    step;
    drive(1'b1, 1'b1, 2'b00, 5'd3, 5'd7, 5'd0, 1'b1);
    total++; if (obs !== {1'b1, 5'd7, 2'b01, 2'b11}) begin bad++; $display("FAIL raw_rsp got=%b exp=%b", obs, {1'b1, 5'd7, 2'b01, 2'b11}); end
    step;
    drive(1'b1, 1'b1, 2'b00, 5'd3, 5'd7, 5'd0, 1'b0);
    total++; if (obs !== {1'b1, 5'd3, 2'b00, 2'b00}) begin bad++; $display("FAIL raw_accept got=%b exp=%b", obs, {1'b1, 5'd3, 2'b00, 2'b00}); end
    step;
  endtask
  task automatic test_back_to_back;
    drive(1'b1, 1'b1, 2'b01, 5'd7, 5'd0, 5'd0, 1'b0); step;
    drive(1'b1, 1'b1, 2'b10, 5'd1, 5'd0, 5'd0, 1'b1);
    total++; if (obs !== {1'b1, 5'd7, 2'b01, 2'b11}) begin bad++; $display("FAIL conflict_rsp got=%b exp=%b", obs, {1'b1, 5'd7, 2'b01, 2'b11}); end
    step;
    drive(1'b1, 1'b1, 2'b10, 5'd1, 5'd0, 5'd0, 1'b0);
    total++; if (obs !== {1'b1, 5'd1, 2'b10, 2'b00}) begin bad++; $display("FAIL conflict_jal got=%b exp=%b", obs, {1'b1, 5'd1, 2'b10, 2'b00}); end
    step;
  endtask
  task automatic test_wait_hazards;
    drive(1'b1, 1'b1, 2'b01, 5'd7, 5'd0, 5'd0, 1'b0); step;
    drive(1'b1, 1'b1, 2'b00, 5'd4, 5'd1, 5'd2, 1'b0);
    total++; if (obs !== {1'b1, 5'd4, 2'b00, 2'b01}) begin bad++; $display("FAIL wait_alu got=%b exp=%b", obs, {1'b1, 5'd4, 2'b00, 2'b01}); end
    step;
    drive(1'b1, 1'b1, 2'b01, 5'd8, 5'd1, 5'd2, 1'b0);
    total++; if (obs !== 10'b0000000011) begin bad++; $display("FAIL second_load got=%b exp=%b", obs, 10'b0000000011); end
    step;
    drive(1'b1, 1'b1, 2'b00, 5'd7, 5'd1, 5'd2, 1'b0);
    total++; if (obs !== 10'b0000000011) begin bad++; $display("FAIL waw got=%b exp=%b", obs, 10'b0000000011); end
    step;
    drive(1'b1, 1'b0, 2'b00, 5'd1, 5'd1, 5'd7, 1'b0);
    total++; if (obs !== 10'b0000000011) begin bad++; $display("FAIL raw_rs2 got=%b exp=%b", obs, 10'b0000000011); end
    step;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b1);
    total++; if (obs !== {1'b1, 5'd7, 2'b01, 2'b01}) begin bad++; $display("FAIL wait_rsp got=%b exp=%b", obs, {1'b1, 5'd7, 2'b01, 2'b01}); end
    step;
  endtask
  task automatic test_noops;
    drive(1'b1, 1'b1, 2'b01, 5'd0, 5'd0, 5'd0, 1'b0);
    total++; if (obs !== 10'b0) begin bad++; $display("FAIL load_x0 got=%b exp=%b", obs, 10'b0); end
    step;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b1);
    total++; if (obs !== 10'b0) begin bad++; $display("FAIL stray_rsp got=%b exp=%b", obs, 10'b0); end
    step;
    drive(1'b1, 1'b1, 2'b11, 5'd6, 5'd0, 5'd0, 1'b0);
    total++; if (obs !== 10'b0) begin bad++; $display("FAIL illegal_src got=%b exp=%b", obs, 10'b0); end
    step;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
    total++; if (obs !== 10'b0) begin bad++; $display("FAIL illegal_after got=%b exp=%b", obs, 10'b0); end
  endtask
  task automatic test_reset_mid;
    drive(1'b1, 1'b1, 2'b01, 5'd7, 5'd0, 5'd0, 1'b0); step;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
    total++; if (load_pending !== 1'b1) begin bad++; $display("FAIL mid_pending got=%b exp=1", load_pending); end
    rst_n = 0; #1;
    total++; if (load_pending !== 1'b0) begin bad++; $display("FAIL mid_reset got=%b exp=0", load_pending); end
    @(negedge clk); rst_n = 1; step;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b1);
    total++; if (obs !== 10'b0) begin bad++; $display("FAIL mid_late_rsp got=%b exp=%b", obs, 10'b0); end
    step;
  endtask
  task automatic test_timeout;
    drive(1'b1, 1'b1, 2'b01, 5'd9, 5'd0, 5'd0, 1'b0); step;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++; if ({load_pending, load_err} !== 2'b10) begin bad++; $display("FAIL to_wait%0d got=%b exp=10", i, {load_pending, load_err}); end
      step;
    end
`ifdef WBS_TIMEOUT_EN
    total++; if ({load_pending, load_err} !== 2'b01) begin bad++; $display("FAIL to_expire got=%b exp=01", {load_pending, load_err}); end
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b1);
    total++; if (ru_wr !== 1'b0) begin bad++; $display("FAIL to_late_rsp got=%b exp=0", ru_wr); end
    step;
    rst_n = 0; #1;
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL to_reset got=%b exp=0", load_err); end
    @(negedge clk); rst_n = 1; step;
`else
    total++; if ({load_pending, load_err} !== 2'b10) begin bad++; $display("FAIL no_timeout got=%b exp=10", {load_pending, load_err}); end
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b1);
    total++; if (obs !== {1'b1, 5'd9, 2'b01, 2'b01}) begin bad++; $display("FAIL no_timeout_rsp got=%b exp=%b", obs, {1'b1, 5'd9, 2'b01, 2'b01}); end
    step;
`endif
  endtask
  initial begin
    test_reset;
    test_alu;
    test_load;
    test_raw;
    test_back_to_back;
    test_wait_hazards;
    test_noops;
    test_reset_mid;
    test_timeout;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_port_sched.md
Name: wb_port_sched

Overview:
- Schedules the single register-file write port between two sources: in-order single-cycle writebacks and one outstanding variable-latency load response.
- Single-cycle writebacks are ALU result (src 2'b00) and PC+offset link (src 2'b10).
- The load response is load data (src 2'b01).
- Drives the writeback-mux select, the RF write enable and the RF destination, and stalls the front end on load hazards and port conflicts.
- Sits between the decoder/data-memory response and the register unit.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles a load may stay outstanding before load_err (used only with WBS_TIMEOUT_EN).
- CNT_W, 7, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  decoded instruction present this cycle.
- wb_en  input  1  instruction writes a register.
- wb_src  input  2  writeback source: 00 ALU, 01 load, 10 PC+offset, 11 illegal.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- mem_rsp_valid  input  1  load data valid this cycle.
- ru_data_wr_src  output  2  writeback-mux select.
- ru_wr  output  1  RF write enable.
- ru_rd  output  5  RF write address.
- stall  output  1  hold PC/instruction this cycle.
- load_pending  output  1  a load is outstanding.
- load_err  output  1  sticky timeout error.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pend_rd=0, wait_cnt=0, load_err=0. Combinational outputs settle to ru_wr=0, ru_data_wr_src=00, ru_rd=0, stall=0, load_pending=0.
- States: IDLE and WAIT_LOAD. load_pending = (state==WAIT_LOAD).
- "accept" = instr_valid & ~stall.
- IDLE, accept, wb_src in {00,10}: same-cycle write.
  - ru_wr = wb_en & (rd!=0); ru_rd=rd; ru_data_wr_src=wb_src.
- IDLE, accept, wb_src=01, wb_en, rd!=0:
  - no write this cycle.
  - Latch pend_rd=rd, clear wait_cnt, go to WAIT_LOAD next edge.
- Load with rd=0: treated as no-write. No state change, no stall; any mem_rsp_valid for it is ignored.
- wb_src=11 with wb_en: no write, no state change.
- WAIT_LOAD, mem_rsp_valid:
  - ru_wr=1, ru_rd=pend_rd, ru_data_wr_src=01.
  - Return to IDLE next edge.
- WAIT_LOAD, no response: wait_cnt increments, saturating.
- stall is asserted in WAIT_LOAD when instr_valid and any of:
  - (a) rs1==pend_rd or rs2==pend_rd (RAW);
  - (b) wb_en & rd==pend_rd (WAW);
  - (c) wb_src=01 & wb_en & rd!=0 (second outstanding load; depth 1);
  - (d) mem_rsp_valid & wb_en & rd!=0 (port conflict; load wins).
- Otherwise, in WAIT_LOAD, non-conflicting single-cycle writes are accepted and written in the same cycle as in IDLE.
- Same-cycle response + dependent instruction: stalled exactly that cycle, accepted next cycle.
- mem_rsp_valid in IDLE: ignored; no write.
- rst_n asserted mid-WAIT_LOAD: pending load is dropped; a later response is ignored.
- Writeback is never issued to x0.

Optional Feature:
- Macro WBS_TIMEOUT_EN.
- Defined:
  - In WAIT_LOAD, when wait_cnt reaches TIMEOUT_CYCLES-1 with no response: set load_err (sticky until reset) and return to IDLE without writing.
  - A later mem_rsp_valid is ignored.
- Undefined:
  - No timeout; WAIT_LOAD persists until a response arrives.
  - load_err is tied 0 and the counter is not instantiated.

Test Plan:
- Reset, then ADD rd=5 src=00 wb_en=1 -> same cycle ru_wr=1, ru_rd=5, ru_data_wr_src=00, stall=0.
- Load rd=7 src=01; response 3 cycles later -> load_pending=1 for 3 cycles. On response cycle ru_wr=1, ru_rd=7, src=01; load_pending=0 next cycle.
- During pending rd=7, instruction rs1=7 -> stall=1 until the response cycle. Instruction accepted the cycle after, with ru_rd=its rd.
- During pending rd=7, response arrives with JAL rd=1 src=10 -> response written (ru_rd=7, src=01), stall=1. JAL written next cycle with ru_rd=1, src=10.
- Load rd=0 -> no state change, ru_wr=0. Stray mem_rsp_valid in IDLE -> ru_wr=0.
- WBS_TIMEOUT_EN, TIMEOUT_CYCLES=4: load rd=9, no response -> after 4 cycles load_err=1, state IDLE. Later response -> ru_wr=0. rst_n low -> load_err=0.
